fetch_prefetch_unit: RTL and testbench

Parametrised successor to the single-instruction fetcher FSM. It keeps a FIFO of up to DEPTH prefetched instructions and issues word-aligned read requests over the existing proc_req/mem_rdy/valid/RDATA memory handshake. It supports a pipeline redirect, which flushes the buffer and discards stale responses. It sits between instruction memory and decode, and decode pops instructions with a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_prefetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO with flush; flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != DEPTH_CNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: one outstanding word read, DEPTH-entry buffer to decode.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      bits     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [bits-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [bits-1:0] redirect_pc,
  output logic            proc_req,
  output logic            we,
  output logic [bits-1:0] ADDR_OUT,
  input  logic            mem_rdy,
  input  logic            valid,
  input  logic [bits-1:0] RDATA,
  output logic            PC_en,
  output logic            instr_valid,
  output logic [bits-1:0] INSTR_OUT,
  output logic [bits-1:0] PC_OUT,
  input  logic            instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [bits-1:0] pc;
    logic [bits-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  fetch_state_t     state_q, state_d;
  logic [bits-1:0]  fetch_pc_q, fetch_pc_d;
  logic [bits-1:0]  req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  logic [ENTRY_W-1:0] head_raw;
  fetch_entry_t     head_entry;
  fetch_entry_t     push_entry;
  logic             accept;
  logic             push;
  logic             pop;
  logic [bits-1:0]  redirect_aligned;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_aligned    = {redirect_pc[bits-1:2], 2'b00};

  // Handshake decode; outputs are forced low while reset is held.
  assign proc_req    = !rst && (state_q == REQ);
  assign we          = 1'b0;
  assign ADDR_OUT    = rst ? '0 : fetch_pc_q;
  assign accept      = proc_req && mem_rdy;
  assign PC_en       = accept && !redirect_valid;
  assign instr_valid = !rst && (count != '0);
  assign head_entry  = head_raw;
  assign INSTR_OUT   = instr_valid ? head_entry.instr : '0;
  assign PC_OUT      = instr_valid ? head_entry.pc : '0;

  assign pop         = instr_valid && instr_ready;
  assign push        = (state_q == WAIT) && valid && !redirect_valid;
  assign push_entry  = '{pc: req_pc_q, instr: RDATA};
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop && !redirect_valid),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head_raw)
  );

  // State, fetch address and in-flight request address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Next-state logic; a redirect overrides the normal transitions.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;

    case (state_q)
      REQ: begin
        if (accept) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + bits'(INSTR_BYTES);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (valid) state_d = (count_after < DEPTH_CNT) ? REQ : HOLD;
      end
      HOLD: begin
        if (count_after < DEPTH_CNT) state_d = REQ;
      end
      DROP: begin
        if (valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      case (state_q)
        REQ:     state_d = accept ? DROP : REQ;
        WAIT:    state_d = valid ? REQ : DROP;
        DROP:    state_d = valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  // A response is only legal while one is outstanding.
  a_no_spurious_valid: assert property (@(posedge clk) disable iff (rst)
    !(valid && (state_q == REQ || state_q == HOLD)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios then random traffic vs. a queue model.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        proc_req;
  logic        we;
  logic [31:0] ADDR_OUT;
  logic        mem_rdy;
  logic        valid;
  logic [31:0] RDATA;
  logic        PC_en;
  logic        instr_valid;
  logic [31:0] INSTR_OUT;
  logic [31:0] PC_OUT;
  logic        instr_ready;

  fetch_prefetch_unit #(
    .bits     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .proc_req       (proc_req),
    .we             (we),
    .ADDR_OUT       (ADDR_OUT),
    .mem_rdy        (mem_rdy),
    .valid          (valid),
    .RDATA          (RDATA),
    .PC_en          (PC_en),
    .instr_valid    (instr_valid),
    .INSTR_OUT      (INSTR_OUT),
    .PC_OUT         (PC_OUT),
    .instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: buffered instructions, next fetch address, in-flight status.
  ent_t        q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  int          inflight;   // 0 none, 1 live, 2 stale

  // Memory model: response countdown and data for the single outstanding read.
  int          mem_cnt;
  int          lat;
  logic [31:0] mem_data;

  int n_assert;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model at negedge, advance model and memory.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic mr, input logic ir);
    logic        exp_req;
    logic        exp_iv;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        acc_dut;
    logic        vld;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_rdy        = mr;
    instr_ready    = ir;
    vld            = !r && (mem_cnt == 1);
    valid          = vld;
    RDATA          = vld ? mem_data : $urandom();
    exp_req   = !r && (inflight == 0) && (q.size() < DEPTH);
    exp_iv    = !r && (q.size() > 0);
    exp_instr = exp_iv ? q[0].instr : 32'h0;
    exp_pc    = exp_iv ? q[0].pc : 32'h0;

    @(negedge clk);
    check("proc_req", 32'(proc_req), 32'(exp_req));
    check("we", 32'(we), 32'h0);
    check("PC_en", 32'(PC_en), 32'(exp_req && mr && !rv));
    check("instr_valid", 32'(instr_valid), 32'(exp_iv));
    check("INSTR_OUT", INSTR_OUT, exp_instr);
    check("PC_OUT", PC_OUT, exp_pc);
    if (r || exp_req) check("ADDR_OUT", ADDR_OUT, r ? 32'h0 : m_fetch_pc);
    acc_dut = proc_req && mem_rdy;

    if (r) begin
      q.delete();
      m_fetch_pc = RESET_PC;
      inflight   = 0;
    end else if (rv) begin
      q.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
      if (exp_req && mr)          inflight = 2;
      else if (inflight != 0 && vld) inflight = 0;
      else if (inflight != 0)     inflight = 2;
    end else begin
      if (exp_iv && ir) void'(q.pop_front());
      if (inflight != 0 && vld) begin
        if (inflight == 1) q.push_back('{pc: m_req_pc, instr: RDATA});
        inflight = 0;
      end
      if (exp_req && mr) begin
        inflight   = 1;
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end

    if (r) mem_cnt = 0;
    else begin
      if (mem_cnt > 0) mem_cnt--;
      if (acc_dut) begin
        mem_cnt  = lat;
        mem_data = {ADDR_OUT[23:0], 8'($urandom())};
      end
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    inflight = 0;
    m_fetch_pc = RESET_PC;
    m_req_pc = 32'h0;
    mem_cnt  = 0;
    mem_data = 32'h0;
    lat      = 1;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_rdy = 1'b0; valid = 1'b0; RDATA = 32'h0; instr_ready = 1'b0;

    // Reset: outputs low during reset, REQ at RESET_PC afterwards.
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_req", 32'(proc_req), 32'h1);
    check("post_rst_addr", ADDR_OUT, RESET_PC);
    check("post_rst_iv", 32'(instr_valid), 32'h0);

    // Streaming with a 1-cycle memory and decode always ready.
    lat = 1;
    repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Fill the buffer with decode stalled, then pop once from HOLD.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("hold_req", 32'(proc_req), 32'h0);
    check("hold_iv", 32'(instr_valid), 32'h1);
    check("hold_head_pc", PC_OUT, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("resume_req", 32'(proc_req), 32'h1);
    check("resume_addr", ADDR_OUT, 32'h10);

    // Memory not ready: request held stable, no PC_en until accepted.
    repeat (3) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("stall_addr", ADDR_OUT, 32'h10);
      check("stall_pc_en", 32'(PC_en), 32'h0);
    end
    mem_rdy = 1'b1;
    #1;
    check("stall_release_pc_en", 32'(PC_en), 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Redirect while waiting; stale response arrives one cycle later.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    lat = 2;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h103, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("drop_req", 32'(proc_req), 32'h1);
    check("drop_addr", ADDR_OUT, 32'h100);
    check("drop_iv", 32'(instr_valid), 32'h0);
    lat = 1;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("redir_head_iv", 32'(instr_valid), 32'h1);
    check("redir_head_pc", PC_OUT, 32'h100);

    // Redirect coinciding with a response and a pop.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h2000, 1'b0, 1'b1);
    check("redir_valid_iv", 32'(instr_valid), 32'h0);
    check("redir_valid_req", 32'(proc_req), 32'h1);
    check("redir_valid_addr", ADDR_OUT, 32'h2000);

    // Address wrap at the top of the space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("wrap_start", ADDR_OUT, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_req", 32'(proc_req), 32'h1);
    check("wrap_addr", ADDR_OUT, 32'h0);

    // Reset while a request is outstanding.
    lat = 3;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    valid = 1'b0;
    #1;
    check("mid_rst_req", 32'(proc_req), 32'h1);
    check("mid_rst_addr", ADDR_OUT, RESET_PC);
    check("mid_rst_iv", 32'(instr_valid), 32'h0);

    // Random traffic: stalls, variable latency, redirects and occasional reset.
    repeat (3000) begin
      logic        r_r, r_rv, r_mr, r_ir;
      logic [31:0] r_pc;
      r_r  = ($urandom_range(0, 199) == 0);
      r_rv = ($urandom_range(0, 19) == 0);
      r_pc = $urandom();
      r_mr = ($urandom_range(0, 9) < 7);
      r_ir = 1'($urandom_range(0, 1));
      lat  = int'($urandom_range(1, 3));
      cycle(r_r, r_rv, r_pc, r_mr, r_ir);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
